// File: rtl/adc_cap_trig.sv
// rtl/adc_cap_trig.sv - ADC stream capture into a BRAM ring buffer with pre-trigger support
//
// Ports:
//   clk_i, rst_i           sole clock, synchronous active-high reset
//   s_axis_tdata/tvalid    ADC beats; invalid beats are dropped
//   s_axis_tready          tied high, the source is never stalled
//   arm_i                  rising edge starts a capture (honoured in IDLE/DONE only)
//   trig_i                 level trigger, looked at only while ARMED
//   mode_i, pretrig_i      start mode and pre-trigger depth, sampled at arm
//   busy_o, done_o         capture in progress / capture complete
//   trig_addr_o            word address of the first post-trigger word
//   bram_*                 write-only BRAM port (byte addressed, read data unused)
module adc_cap_trig #(
    parameter int DWIDTH_IN = 128,
    parameter int PACK      = 2,
    parameter int MAX_XFER  = 2048
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [DWIDTH_IN-1:0]              s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              arm_i,
    input  logic                              trig_i,
    input  logic                              mode_i,
    input  logic [$clog2(MAX_XFER)-1:0]       pretrig_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [$clog2(MAX_XFER)-1:0]       trig_addr_o,
    output logic [DWIDTH_IN*PACK-1:0]         bram_wdata,
    output logic [DWIDTH_IN*PACK/8-1:0]       bram_we,
    output logic                              bram_en,
    input  logic [DWIDTH_IN*PACK-1:0]         bram_rdata,
    output logic [31:0]                       bram_addr,
    output logic                              bram_clk,
    output logic                              bram_rst
);

    localparam int DWIDTH_OUT = DWIDTH_IN * PACK;
    localparam int ADDR_BITS  = $clog2(MAX_XFER);
    localparam int WE_BITS    = DWIDTH_OUT / 8;
    localparam int BYTE_SHIFT = $clog2(WE_BITS);
    localparam int PCW        = (PACK > 1) ? $clog2(PACK) : 1;

    localparam logic [PCW-1:0]       PACK_LAST  = PCW'(PACK - 1);
    localparam logic [ADDR_BITS:0]   XFER_WORDS = (ADDR_BITS + 1)'(MAX_XFER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                  arm_q;
    logic [ADDR_BITS-1:0]  pretrig_r;
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  pre_cnt;
    logic [ADDR_BITS:0]    post_cnt;
    logic [PCW-1:0]        pack_cnt;
    logic [DWIDTH_OUT-1:0] pack_buf;
    logic [DWIDTH_OUT-1:0] packed_word;

    logic arm_pulse;
    logic start;
    logic capturing;
    logic pre_hit;
    logic post_hit;
    logic trig_hit;
    logic beat_take;
    logic unused_bits;

    assign s_axis_tready = 1'b1;
    assign bram_clk      = clk_i;
    assign bram_rst      = rst_i;
    assign bram_we       = {WE_BITS{bram_en}};
    assign bram_addr     = 32'(wr_ptr) << BYTE_SHIFT;

    // The top slot of pack_buf is never stored: the last beat goes straight
    // into the outgoing word.
    assign unused_bits = ^{bram_rdata, pack_buf[DWIDTH_OUT-1 -: DWIDTH_IN]};

    assign arm_pulse = arm_i & ~arm_q;
    assign start     = arm_pulse && (state == S_IDLE || state == S_DONE);
    assign capturing = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);

    // Word counts advance on the cycle the write strobe is actually out.
    assign pre_hit  = (state == S_PRE) && bram_en &&
                      (({1'b0, pre_cnt} + 1'b1) == {1'b0, pretrig_r});
    assign post_hit = (state == S_POST) && bram_en &&
                      ((post_cnt + 1'b1) == (XFER_WORDS - {1'b0, pretrig_r}));
    assign trig_hit = (state == S_ARMED) && trig_i;

    // No beat is accepted on the cycle the final word goes out, so nothing
    // can be written once DONE is reached.
    assign beat_take = capturing && !post_hit && s_axis_tvalid;

    always_comb begin
        packed_word = pack_buf;
        packed_word[(PACK-1)*DWIDTH_IN +: DWIDTH_IN] = s_axis_tdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_o    = capturing;
        done_o    = (state == S_DONE);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (!mode_i || pretrig_i == '0) ? S_POST : S_PRE;
                end
            end
            S_PRE: begin
                if (pre_hit) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (trig_i) state_nxt = S_POST;
            end
            S_POST: begin
                if (post_hit) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            arm_q       <= 1'b0;
            pretrig_r   <= '0;
            wr_ptr      <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            pack_cnt    <= '0;
            pack_buf    <= '0;
            bram_wdata  <= '0;
            bram_en     <= 1'b0;
            trig_addr_o <= '0;
        end else begin
            arm_q   <= arm_i;
            bram_en <= 1'b0;
            if (start) begin
                // Immediate mode behaves as a zero-depth pre-trigger capture.
                pretrig_r   <= mode_i ? pretrig_i : '0;
                wr_ptr      <= '0;
                pre_cnt     <= '0;
                post_cnt    <= '0;
                pack_cnt    <= '0;
                trig_addr_o <= '0;
            end else begin
                if (bram_en) wr_ptr <= wr_ptr + 1'b1;
                if (state == S_PRE && bram_en) pre_cnt <= pre_cnt + 1'b1;
                if (state == S_POST && bram_en) post_cnt <= post_cnt + 1'b1;
                if (trig_hit) begin
                    // A write in the trigger cycle belongs to the pre-trigger side.
                    trig_addr_o <= bram_en ? wr_ptr + 1'b1 : wr_ptr;
                    post_cnt    <= '0;
                end
                if (beat_take) begin
                    if (pack_cnt == PACK_LAST) begin
                        bram_wdata <= packed_word;
                        bram_en    <= 1'b1;
                        pack_cnt   <= '0;
                    end else begin
                        pack_buf[int'(pack_cnt)*DWIDTH_IN +: DWIDTH_IN] <= s_axis_tdata;
                        pack_cnt <= pack_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_cap_trig.sv
// tb/tb_adc_cap_trig.sv - directed self-checking bench for adc_cap_trig
module tb_adc_cap_trig;

    localparam int DW = 16;
    localparam int PK = 2;
    localparam int MX = 16;
    localparam int DO = DW * PK;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          arm_i = 1'b0;
    logic          trig_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [3:0]    pretrig_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [3:0]    trig_addr_o;
    logic [DO-1:0] bram_wdata;
    logic [DO/8-1:0] bram_we;
    logic          bram_en;
    logic [DO-1:0] bram_rdata = '0;
    logic [31:0]   bram_addr;
    logic          bram_clk;
    logic          bram_rst;

    adc_cap_trig #(.DWIDTH_IN(DW), .PACK(PK), .MAX_XFER(MX)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .arm_i         (arm_i),
        .trig_i        (trig_i),
        .mode_i        (mode_i),
        .pretrig_i     (pretrig_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .trig_addr_o   (trig_addr_o),
        .bram_wdata    (bram_wdata),
        .bram_we       (bram_we),
        .bram_en       (bram_en),
        .bram_rdata    (bram_rdata),
        .bram_addr     (bram_addr),
        .bram_clk      (bram_clk),
        .bram_rst      (bram_rst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic toggle = 1'b0;

    logic [31:0]   w_addr[$];
    logic [DO-1:0] w_data[$];
    logic [3:0]    w_we[$];
    int            w_cyc[$];
    logic [DO-1:0] mem [MX];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bram_en) begin
            w_addr.push_back(bram_addr);
            w_data.push_back(bram_wdata);
            w_we.push_back(bram_we);
            w_cyc.push_back(cyc);
            mem[bram_addr[5:2]] <= bram_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DO-1:0] word(input int w);
        return {16'(2 * w + 1), 16'(2 * w)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (s_axis_tvalid) s_axis_tdata = s_axis_tdata + 1'b1;
        if (toggle) s_axis_tvalid = ~s_axis_tvalid;
    endtask

    task automatic clear_log();
        w_addr.delete();
        w_data.delete();
        w_we.delete();
        w_cyc.delete();
    endtask

    task automatic arm(input logic m, input logic [3:0] p, input logic tog);
        clear_log();
        mode_i        = m;
        pretrig_i     = p;
        toggle        = 1'b0;
        s_axis_tvalid = 1'b0;
        arm_i         = 1'b1;
        tick();
        arm_i         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b1;
        toggle        = tog;
    endtask

    task automatic wait_writes(input int n, input string tag);
        int k = 0;
        while (w_addr.size() < n && k < 500) begin
            tick();
            k++;
        end
        check(tag, 64'(w_addr.size() >= n), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done_o && k < 500) begin
            tick();
            k++;
        end
        check(tag, 64'(done_o), 64'd1);
    endtask

    task automatic check_seq(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            check({tag, "_addr"}, 64'(w_addr[k]), 64'(4 * (k % MX)));
            check({tag, "_data"}, 64'(w_data[k]), 64'(word(k)));
            check({tag, "_we"}, 64'(w_we[k]), 64'hF);
        end
    endtask

    initial begin
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_en", 64'(bram_en), 64'd0);
        check("rst_trig_addr", 64'(trig_addr_o), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_wdata", 64'(bram_wdata), 64'd0);
        check("tready", 64'(s_axis_tready), 64'd1);

        // Immediate mode, continuous valid
        arm(1'b0, 4'd0, 1'b0);
        check("t1_busy", 64'(busy_o), 64'd1);
        wait_done("t1_done");
        check("t1_nwr", 64'(w_addr.size()), 64'd16);
        check_seq("t1", 16);
        check("t1_trig_addr", 64'(trig_addr_o), 64'd0);
        repeat (6) tick();
        check("t1_no_extra", 64'(w_addr.size()), 64'd16);
        check("t1_done_hold", 64'(done_o), 64'd1);
        check("t1_busy_end", 64'(busy_o), 64'd0);

        // Immediate mode, tvalid toggling every cycle
        arm(1'b0, 4'd0, 1'b1);
        wait_done("t2_done");
        check("t2_nwr", 64'(w_addr.size()), 64'd16);
        check_seq("t2", 16);
        check("t2_gap_first", 64'(w_cyc[1] - w_cyc[0]), 64'd4);
        check("t2_gap_last", 64'(w_cyc[15] - w_cyc[14]), 64'd4);
        toggle = 1'b0;

        // External trigger after 10 words, pretrig 4
        arm(1'b1, 4'd4, 1'b0);
        wait_writes(10, "t3_wait10");
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        wait_done("t3_done");
        check("t3_trig_addr", 64'(trig_addr_o), 64'd10);
        check("t3_nwr", 64'(w_addr.size()), 64'd22);
        check_seq("t3", 22);
        for (int a = 0; a < MX; a++) begin
            check("t3_mem", 64'(mem[a]), 64'(word(a < 6 ? a + 16 : a)));
        end

        // Trigger in PRE ignored, second trigger at word 7
        arm(1'b1, 4'd4, 1'b0);
        wait_writes(2, "t4_wait2");
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        wait_writes(7, "t4_wait7");
        check("t4_trig_addr_pre", 64'(trig_addr_o), 64'd0);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        wait_done("t4_done");
        check("t4_trig_addr", 64'(trig_addr_o), 64'd7);
        check("t4_nwr", 64'(w_addr.size()), 64'd19);
        check("t4_mem3", 64'(mem[3]), 64'(word(3)));
        check("t4_mem6", 64'(mem[6]), 64'(word(6)));
        check("t4_mem2", 64'(mem[2]), 64'(word(18)));

        // Reset during POST, pack about to complete
        arm(1'b0, 4'd0, 1'b0);
        wait_writes(5, "t5_wait5");
        rst_i = 1'b1;
        tick();
        check("t5_en", 64'(bram_en), 64'd0);
        check("t5_busy", 64'(busy_o), 64'd0);
        check("t5_done", 64'(done_o), 64'd0);
        check("t5_addr", 64'(bram_addr), 64'd0);
        rst_i = 1'b0;
        repeat (4) tick();
        check("t5_nwr", 64'(w_addr.size()), 64'd5);
        arm(1'b0, 4'd0, 1'b0);
        wait_done("t5_done2");
        check("t5_nwr2", 64'(w_addr.size()), 64'd16);
        check("t5_first_addr", 64'(w_addr[0]), 64'd0);
        check("t5_first_data", 64'(w_data[0]), 64'(word(0)));

        // Arm while busy and held across DONE
        arm(1'b0, 4'd0, 1'b0);
        wait_writes(3, "t6_wait3");
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        check("t6_busy_mid", 64'(busy_o), 64'd1);
        wait_writes(10, "t6_wait10");
        arm_i = 1'b1;
        wait_done("t6_done");
        check("t6_nwr", 64'(w_addr.size()), 64'd16);
        check_seq("t6", 16);
        repeat (5) tick();
        check("t6_done_hold", 64'(done_o), 64'd1);
        check("t6_busy_hold", 64'(busy_o), 64'd0);
        check("t6_no_extra", 64'(w_addr.size()), 64'd16);
        arm_i = 1'b0;
        tick();
        arm(1'b0, 4'd0, 1'b0);
        check("t6_rearm_busy", 64'(busy_o), 64'd1);
        check("t6_rearm_done", 64'(done_o), 64'd0);
        wait_done("t6_done2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_cap_trig.md
Name: adc_cap_trig

Overview:
- Single-clock successor to the free-running ADC-to-BRAM capture block.
- Packs PACK consecutive valid input beats into one BRAM word, honours tvalid, and runs the BRAM as a ring buffer.
- Supports a programmable pre-trigger depth and two start modes: immediate and external trigger.
- Sits between an RFDC ADC AXI4-Stream output and a Xilinx BRAM port read back by the PS.

Parameters:
- DWIDTH_IN, 128, input beat width in bits.
- PACK, 2, input beats per BRAM word; power of 2, ≥1. Localparam DWIDTH_OUT = DWIDTH_IN*PACK.
- MAX_XFER, 2048, BRAM depth in words; power of 2. Localparam ADDR_BITS = clog2(MAX_XFER).

Ports:
- Interface (already decided): one clock; reset is synchronous and active-high.
- clk_i  in  1  sole clock. Stream, control and BRAM all run on it.
- rst_i  in  1  synchronous active-high reset.
- s_axis_tdata  in  DWIDTH_IN  ADC sample beat.
- s_axis_tvalid  in  1  beat valid; beats with tvalid=0 are dropped.
- s_axis_tready  out  1  tied 1; streaming source, no backpressure.
- arm_i  in  1  rising edge starts a capture.
- trig_i  in  1  level trigger, sampled only in ARMED.
- mode_i  in  1  0 = immediate (no pretrigger wait), 1 = external trigger. Sampled at arm.
- pretrig_i  in  ADDR_BITS  pre-trigger words. Sampled at arm.
- busy_o  out  1  high in PRE/ARMED/POST.
- done_o  out  1  high in DONE.
- trig_addr_o  out  ADDR_BITS  word address of the first post-trigger word.
- bram_wdata  out  DWIDTH_OUT  write data.
- bram_we  out  DWIDTH_OUT/8  all bits equal bram_en.
- bram_en  out  1  one-cycle write strobe per packed word.
- bram_rdata  in  DWIDTH_OUT  unused.
- bram_addr  out  32  byte address = wr_ptr << clog2(DWIDTH_OUT/8), upper bits 0.
- bram_clk  out  1  = clk_i.
- bram_rst  out  1  = rst_i.

Behaviour:
- Reset values:
  - State IDLE; busy_o=0, done_o=0, bram_en=0.
  - wr_ptr=0, trig_addr_o=0, pack count 0, arm edge register 0, bram_wdata=0.
  - Reset mid-capture aborts on the next edge: no further writes, partial pack discarded.
- Arm edge detect: arm_q registered; arm_pulse = arm_i & ~arm_q.
  - Honoured only in IDLE or DONE; ignored while busy.
- Packing:
  - Each valid beat goes into slot pack_cnt; slot 0 = LSBs.
  - On the PACK-th valid beat (cycle n), the word is written at cycle n+1: bram_en=1, addr=wr_ptr, data=packed word. wr_ptr then increments mod MAX_XFER (wrap 2^ADDR_BITS-1 -> 0).
  - Packing and writes occur only in PRE/ARMED/POST.
  - pack_cnt is cleared on arm, so word 0 always starts at a beat boundary after arm.
  - Valid gaps stall packing without corrupting it.
- State machine:
  - IDLE/DONE: on arm_pulse, latch mode/pretrig, set wr_ptr=0, pre_cnt=0.
    - Then -> POST if mode=0 or pretrig=0, with trig_addr_o=0.
    - Otherwise -> PRE.
  - PRE: count words written; when pre_cnt reaches pretrig -> ARMED. trig_i is ignored in PRE.
  - ARMED: ring keeps writing (wraps, overwriting oldest). On the first cycle trig_i=1:
    - trig_addr_o = address the next word will be written to (wr_ptr, or wr_ptr+1 if a write occurs that cycle).
    - -> POST with post_cnt=0.
  - POST: count words; after MAX_XFER - pretrig words (MAX_XFER for mode 0) -> DONE. No write after the last counted word.
- Trigger coinciding with a write in ARMED: that write is pre-trigger.
- Result: BRAM holds exactly pretrig words before trig_addr_o (circularly) and MAX_XFER-pretrig from it.
- done_o stays high until the next arm or reset; trig_addr_o holds until the next arm.

Test Plan:
- Bench config DWIDTH_IN=16, PACK=2, MAX_XFER=16. Input = incrementing counter, tvalid=1, mode=0, arm.
  - -> 16 writes to addrs 0..15 (byte 0,4,...,60), word k = {2k+1,2k}; done_o after write 15; trig_addr_o=0.
- tvalid toggled 1,0,1,0 during mode 0.
  - -> same packed data ordering; one write per 4 cycles; no duplicated or lost samples.
- mode=1, pretrig=4, trig_i after 10 words written.
  - -> trig_addr_o=10; exactly 12 more writes (addrs 10..15,0..5); final BRAM has 4 pre-trigger words at 6..9.
- mode=1, pretrig=4, trig_i pulsed during PRE (word 2), then again at word 7.
  - -> first pulse ignored; trig_addr_o=7.
- rst_i asserted in POST after 5 writes.
  - -> bram_en=0 next cycle; busy_o=0, done_o=0; a following arm restarts at addr 0.
- arm_i pulsed while busy, and held high across DONE.
  - -> ignored; a new capture starts only on a fresh rising edge.
